sub32_pipe: RTL and testbench



---
 rtl/sub_pkg.sv | 25 ++
 rtl/sub_half.sv | 23 ++
 rtl/sub32_pipe.sv | 114 +++++++++++
 tb/tb_sub32_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types for the two-stage pipelined subtractor.
// DATA_W sets the operand width, and HALF sets the width of each pipeline slice.
// Struct widths follow HALF, so the top-level N must equal DATA_W.
package sub_pkg;

  localparam int DATA_W = 32;
  localparam int HALF   = DATA_W / 2;

  // Stage-1 payload: low-half difference, carry into the high half, raw high operands.
  typedef struct packed {
    logic [HALF-1:0] low;
    logic            carry;
    logic [HALF-1:0] a_hi;
    logic [HALF-1:0] b_hi;
  } s1_payload_t;

  // Condition flags derived from the final difference.
  typedef struct packed {
    logic borrow;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/sub_half.sv
// Purpose: W-bit slice computing a + ~b + cin, with the carry out on cout.
// Latency: combinational.
// Backpressure: none (pure datapath).
module sub_half #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total;

  // Extend by one bit so the carry out falls out of the add.
  always_comb begin
    total = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
    sum   = total[W-1:0];
    cout  = total[W];
  end

endmodule

// File: rtl/sub32_pipe.sv
// Purpose: registered A - B - borrow_in plus borrow/zero/neg/ovf flags, split across two half-width stages.
// Latency: 2 cycles from input accept to out_valid, with a throughput of 1 per cycle.
// Backpressure: holds 2 transactions under stall; in_ready follows out_ready combinationally.
module sub32_pipe
  import sub_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] operA,
  input  logic [N-1:0] operB,
  input  logic         borrow_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] resultOUT,
  output logic         borrow_out,
  output logic         zero,
  output logic         neg,
  output logic         ovf
);

  localparam int H = HALF;

  s1_payload_t  s1_q;
  logic         s1_valid;
  logic         s2_valid;
  logic [N-1:0] res_q;
  flags_t       flg_q;

  logic         s1_load;
  logic         s2_load;
  logic [H-1:0] lo_sum;
  logic         lo_cout;
  logic [H-1:0] hi_sum;
  logic         hi_cout;
  logic [N-1:0] res_nxt;
  flags_t       flg_nxt;

  // A borrow in is the same as dropping the +1 of the two's complement, so cin = ~borrow_in.
  sub_half #(.W(H)) u_lo (
    .a    (operA[H-1:0]),
    .b    (operB[H-1:0]),
    .cin  (~borrow_in),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  sub_half #(.W(H)) u_hi (
    .a    (s1_q.a_hi),
    .b    (s1_q.b_hi),
    .cin  (s1_q.carry),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  // Handshake: each stage advances only when its downstream slot is free or is draining.
  always_comb begin
    s2_load  = s1_valid && (!s2_valid || out_ready);
    in_ready = !rst && (!s1_valid || !s2_valid || out_ready);
    s1_load  = in_valid && in_ready;
  end

  // Assemble the final difference and its flags. Signs come from the stored high operands.
  always_comb begin
    res_nxt        = {hi_sum, s1_q.low};
    flg_nxt        = '0;
    flg_nxt.borrow = ~hi_cout;
    flg_nxt.zero   = (res_nxt == '0);
    flg_nxt.neg    = hi_sum[H-1];
    flg_nxt.ovf    = (s1_q.a_hi[H-1] != s1_q.b_hi[H-1]) && (hi_sum[H-1] != s1_q.a_hi[H-1]);
  end

  // Stage 1: capture the low-half result and the raw high halves on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid    <= 1'b1;
      s1_q.low    <= lo_sum;
      s1_q.carry  <= lo_cout;
      s1_q.a_hi   <= operA[N-1:H];
      s1_q.b_hi   <= operB[N-1:H];
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: result register. It only changes when empty or draining, so the payload is stable under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      res_q    <= '0;
      flg_q    <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      res_q    <= res_nxt;
      flg_q    <= flg_nxt;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid  = s2_valid;
  assign resultOUT  = res_q;
  assign borrow_out = flg_q.borrow;
  assign zero       = flg_q.zero;
  assign neg        = flg_q.neg;
  assign ovf        = flg_q.ovf;

endmodule

// File: tb/tb_sub32_pipe.sv
// Directed bench for sub32_pipe: reset state, hand-computed vectors, streaming, stall and mid-flight reset.
module tb_sub32_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operA;
  logic [31:0] operB;
  logic        borrow_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] resultOUT;
  logic        borrow_out;
  logic        zero;
  logic        neg;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  sub32_pipe #(.N(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operA      (operA),
    .operB      (operB),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .resultOUT  (resultOUT),
    .borrow_out (borrow_out),
    .zero       (zero),
    .neg        (neg),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 33-bit subtraction. Packed as {result, borrow, zero, neg, ovf}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] d;
    logic [31:0] r;
    d = {1'b0, a} - {1'b0, b} - {32'b0, bin};
    r = d[31:0];
    return {r, d[32], (r == 32'd0), r[31], (a[31] != b[31]) && (r[31] != a[31])};
  endfunction

  function automatic logic [63:0] obs_pkt();
    return {28'd0, resultOUT, borrow_out, zero, neg, ovf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] va   [6];
  logic [31:0] vb   [6];
  logic        vbin [6];
  logic [35:0] vexp [6];
  logic [31:0] sa   [8];
  logic [31:0] sb   [8];
  logic        sbin [8];
  logic [35:0] t0, t1, t2;

  initial begin
    va[0] = 32'd5;          vb[0] = 32'd3; vbin[0] = 1'b0; vexp[0] = {32'h0000_0002, 4'b0000};
    va[1] = 32'd0;          vb[1] = 32'd1; vbin[1] = 1'b0; vexp[1] = {32'hFFFF_FFFF, 4'b1010};
    va[2] = 32'd7;          vb[2] = 32'd7; vbin[2] = 1'b0; vexp[2] = {32'h0000_0000, 4'b0100};
    va[3] = 32'd7;          vb[3] = 32'd7; vbin[3] = 1'b1; vexp[3] = {32'hFFFF_FFFF, 4'b1010};
    va[4] = 32'h0001_0000;  vb[4] = 32'd1; vbin[4] = 1'b0; vexp[4] = {32'h0000_FFFF, 4'b0000};
    va[5] = 32'h8000_0000;  vb[5] = 32'd1; vbin[5] = 1'b0; vexp[5] = {32'h7FFF_FFFF, 4'b0001};

    rst = 1'b1; in_valid = 1'b0; operA = '0; operB = '0; borrow_in = 1'b0; out_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_payload", obs_pkt(), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed single transactions
    for (int i = 0; i < 6; i++) begin
      operA = va[i]; operB = vb[i]; borrow_in = vbin[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_lat1_valid", i), {63'd0, out_valid}, 64'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d_payload", i), obs_pkt(), {28'd0, vexp[i]});
      tick();
      chk($sformatf("vec%0d_drained", i), {63'd0, out_valid}, 64'd0);
    end

    // Back-to-back stream of 8, one result per cycle
    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom; sb[i] = $urandom; sbin[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        operA = sa[i]; operB = sb[i]; borrow_in = sbin[i]; in_valid = 1'b1;
        chk($sformatf("stream%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 8) begin
        chk($sformatf("stream%0d_valid", i - 1), {63'd0, out_valid}, 64'd1);
        chk($sformatf("stream%0d_payload", i - 1), obs_pkt(), {28'd0, model(sa[i-1], sb[i-1], sbin[i-1])});
      end
    end
    chk("stream_drained", {63'd0, out_valid}, 64'd0);

    // Stall: offer 3 transactions with out_ready low
    t0 = model(32'd100, 32'd40, 1'b0);
    t1 = model(32'h1234_0000, 32'h0000_0001, 1'b1);
    t2 = model(32'd9, 32'd10, 1'b0);
    out_ready = 1'b0;
    operA = 32'd100; operB = 32'd40; borrow_in = 1'b0; in_valid = 1'b1;
    tick();
    chk("stall_in_ready_after_1", {63'd0, in_ready}, 64'd1);
    operA = 32'h1234_0000; operB = 32'h0000_0001; borrow_in = 1'b1;
    tick();
    operA = 32'd9; operB = 32'd10; borrow_in = 1'b0;
    #1;
    chk("stall_in_ready_after_2", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_hold%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
      chk($sformatf("stall_hold%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("stall_hold%0d_payload", i), obs_pkt(), {28'd0, t0});
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("drain1_valid", {63'd0, out_valid}, 64'd1);
    chk("drain1_payload", obs_pkt(), {28'd0, t1});
    tick();
    chk("drain2_valid", {63'd0, out_valid}, 64'd1);
    chk("drain2_payload", obs_pkt(), {28'd0, t2});
    tick();
    chk("drain_done", {63'd0, out_valid}, 64'd0);

    // Mid-flight reset with both stages full
    out_ready = 1'b0;
    operA = 32'd50; operB = 32'd1; in_valid = 1'b1;
    tick();
    operA = 32'd60; operB = 32'd2;
    tick();
    in_valid = 1'b0;
    chk("full_before_rst", {62'd0, out_valid, in_ready}, 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("after_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("after_rst_payload", obs_pkt(), 64'd0);
    chk("after_rst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("no_stale%0d", i), {63'd0, out_valid}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
